layer0_feature_packer: RTL
==========================

# layer0_feature_packer

Input stage directly upstream of the layer-0 LUT neurons. Accepts a stream of signed readout samples, compares each against a per-feature programmable threshold to form a 1-bit feature, packs one frame of N_FEAT features into a vector, and presents it to layer 0 over a valid/ready handshake. A separate output register lets the next frame assemble while the previous vector is still waiting.

## Interface
- N_FEAT, 16, features per frame (width of the vector handed to layer 0); ≥ 2
- SAMPLE_W, 12, width of signed input samples and thresholds
- FCNT_W, 16, width of the emitted-frame counter
- clk  in  1  clock; all logic rising-edge
- rst_n  in  1  asynchronous, active-low reset
- s_valid  in  1  input sample valid
- s_ready  out  1  block accepts sample this cycle
- s_data  in  SAMPLE_W  signed two's-complement sample
- s_last  in  1  marks final sample of a frame
- thr_we  in  1  threshold write strobe
- thr_addr  in  $clog2(N_FEAT)  feature index to write
- thr_data  in  SAMPLE_W  signed threshold value
- m_valid  out  1  packed feature vector valid
- m_ready  in  1  layer 0 accepts vector
- m_feat  out  N_FEAT  packed features; bit i = feature i
- frame_err  out  1  one-cycle pulse on frame length mismatch
- frame_cnt  out  FCNT_W  count of vectors emitted (handshake completions)

## Operation
- Sample accepted when s_valid && s_ready. Sample k of frame (k = 0..N_FEAT-1) sets assembly bit k = (signed(s_data) >= signed(thr[k])).
- Index counter idx: 0 after reset and after every frame completion/discard; increments per accepted sample.
- Threshold file: N_FEAT × SAMPLE_W registers, reset to 0. thr_we writes thr[thr_addr] at the clock edge; comparison in the same cycle uses the old value. thr_addr ≥ N_FEAT ignored.
- Frame completes on accepted sample with idx == N_FEAT-1. Assembly vector (including this sample's bit) loads into m_feat, m_valid set.
- s_ready = 0 only when idx == N_FEAT-1 and m_valid && !m_ready (output register occupied); 1 otherwise, including in DISCARD. s_ready never depends on s_data or s_last.
- Output register: m_feat/m_valid hold stable while m_valid && !m_ready. Load and drain in the same cycle are allowed (back-to-back).
- frame_cnt increments (wraps modulo 2^FCNT_W) on each m_valid && m_ready.
- States (with frame check compiled in): COLLECT (normal), DISCARD (drop samples until s_last accepted).
  - COLLECT, accepted s_last with idx < N_FEAT-1: short frame; discard assembly, idx ← 0, frame_err pulse, stay COLLECT.
  - COLLECT, accepted sample idx == N_FEAT-1 with s_last = 0: long frame; vector is not emitted, frame_err pulse, → DISCARD.
  - DISCARD: accepted samples dropped; accepted s_last → COLLECT, idx ← 0. No additional frame_err.
  - COLLECT, idx == N_FEAT-1 with s_last = 1: normal completion.
- Reset mid-frame: assembly, idx, m_valid cleared; partial frame is lost; thresholds return to 0.

## Timing
- Reset values: s_ready 1, m_valid 0, m_feat 0, frame_err 0, frame_cnt 0, state COLLECT, idx 0.
- Latency: last sample accepted at edge t → m_valid = 1 and m_feat valid after edge t (visible in cycle t+1).
- frame_err is registered: asserted for exactly one cycle following the offending accept edge.
- Throughput: one sample per cycle sustained when m_ready held high; one vector per N_FEAT cycles.
- Threshold write at edge t affects comparisons from cycle t+1.

## Configuration
- LAYER0_PACKER_FRAME_CHECK_EN defined: s_last checked as above, DISCARD state and frame_err are active.
- Not defined: s_last ignored; every N_FEAT accepted samples form a frame; no DISCARD state; frame_err tied to 0.

## Test plan
- Reset, thr all 0, N_FEAT=16: feed samples +1,-1 alternating (k=0..15, last on k=15), m_ready=1 -> m_valid one cycle after last accept, m_feat = 16'h5555, frame_cnt = 1.
- Program thr[3]=100: sample k=3 value 99 -> bit3 = 0; next frame k=3 value 100 -> bit3 = 1; write thr during frame's k=3 cycle -> old threshold used.
- Hold m_ready=0 after frame 1 completes, stream frame 2 continuously -> s_ready drops at idx 15 until m_ready=1; m_feat unchanged while stalled; frame 2 emitted next cycle after drain, no sample lost.
- With FRAME_CHECK_EN: s_last on k=9 -> frame_err 1-cycle pulse, no m_valid; following 16-sample frame emitted correctly.
- With FRAME_CHECK_EN: 20 samples, s_last on 20th -> frame_err once after 16th, samples 17–20 dropped, next good frame emitted; without macro same stimulus emits one vector from samples 1–16, frame_err stays 0.
- Assert rst_n low at idx 7 with m_valid=1 -> all outputs to reset values asynchronously; fresh frame after release emits correctly, frame_cnt restarts at 0.

Source files
------------

// File: rtl/layer0_feature_packer.sv
// rtl/layer0_feature_packer.sv - thresholds signed samples into 1-bit features and packs N_FEAT per frame for layer 0.
// Optional frame-length checking (s_last, DISCARD state, frame_err) is enabled by LAYER0_PACKER_FRAME_CHECK_EN.
module layer0_feature_packer #(
  parameter int N_FEAT   = 16,
  parameter int SAMPLE_W = 12,
  parameter int FCNT_W   = 16,
  localparam int IDX_W   = $clog2(N_FEAT)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [SAMPLE_W-1:0] s_data,
  input  logic                s_last,
  input  logic                thr_we,
  input  logic [IDX_W-1:0]    thr_addr,
  input  logic [SAMPLE_W-1:0] thr_data,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [N_FEAT-1:0]   m_feat,
  output logic                frame_err,
  output logic [FCNT_W-1:0]   frame_cnt
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_FEAT - 1);

  logic [SAMPLE_W-1:0] thr_q [N_FEAT];
  logic [SAMPLE_W-1:0] thr_d [N_FEAT];
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [N_FEAT-1:0]   asm_q, asm_d;
  logic [N_FEAT-1:0]   m_feat_q, m_feat_d;
  logic                m_valid_q, m_valid_d;
  logic [FCNT_W-1:0]   frame_cnt_q, frame_cnt_d;

  logic                last_idx;
  logic                accept;
  logic                cur_bit;
  logic [N_FEAT-1:0]   asm_with_cur;

`ifdef LAYER0_PACKER_FRAME_CHECK_EN
  typedef enum logic {COLLECT, DISCARD} state_t;
  state_t state_q, state_d;
  logic   frame_err_q, frame_err_d;
`else
  logic   unused_s_last;
  assign unused_s_last = s_last;
`endif

  assign last_idx = (idx_q == LAST_IDX);
  // Only a completing sample needs the output register, so stall just at the last index.
  assign s_ready  = !(last_idx && m_valid_q && !m_ready);
  assign accept   = s_valid && s_ready;
  assign cur_bit  = ($signed(s_data) >= $signed(thr_q[idx_q]));

  always_comb begin
    asm_with_cur        = asm_q;
    asm_with_cur[idx_q] = cur_bit;
  end

  always_comb begin
    for (int i = 0; i < N_FEAT; i++) begin
      thr_d[i] = thr_q[i];
    end
    if (thr_we && (32'(thr_addr) < N_FEAT)) begin
      thr_d[thr_addr] = thr_data;
    end
  end

  always_comb begin
    idx_d       = idx_q;
    asm_d       = asm_q;
    m_feat_d    = m_feat_q;
    m_valid_d   = m_valid_q && !m_ready;
    frame_cnt_d = frame_cnt_q + FCNT_W'(m_valid_q && m_ready);
`ifdef LAYER0_PACKER_FRAME_CHECK_EN
    state_d     = state_q;
    frame_err_d = 1'b0;
    if (accept) begin
      if (state_q == DISCARD) begin
        if (s_last) begin
          state_d = COLLECT;
          idx_d   = '0;
          asm_d   = '0;
        end
      end else if (last_idx) begin
        idx_d = '0;
        asm_d = '0;
        if (s_last) begin
          m_feat_d  = asm_with_cur;
          m_valid_d = 1'b1;
        end else begin
          frame_err_d = 1'b1;
          state_d     = DISCARD;
        end
      end else if (s_last) begin
        idx_d       = '0;
        asm_d       = '0;
        frame_err_d = 1'b1;
      end else begin
        idx_d = idx_q + IDX_W'(1);
        asm_d = asm_with_cur;
      end
    end
`else
    if (accept) begin
      if (last_idx) begin
        idx_d     = '0;
        asm_d     = '0;
        m_feat_d  = asm_with_cur;
        m_valid_d = 1'b1;
      end else begin
        idx_d = idx_q + IDX_W'(1);
        asm_d = asm_with_cur;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_FEAT; i++) begin
        thr_q[i] <= '0;
      end
      idx_q       <= '0;
      asm_q       <= '0;
      m_feat_q    <= '0;
      m_valid_q   <= 1'b0;
      frame_cnt_q <= '0;
`ifdef LAYER0_PACKER_FRAME_CHECK_EN
      state_q     <= COLLECT;
      frame_err_q <= 1'b0;
`endif
    end else begin
      for (int i = 0; i < N_FEAT; i++) begin
        thr_q[i] <= thr_d[i];
      end
      idx_q       <= idx_d;
      asm_q       <= asm_d;
      m_feat_q    <= m_feat_d;
      m_valid_q   <= m_valid_d;
      frame_cnt_q <= frame_cnt_d;
`ifdef LAYER0_PACKER_FRAME_CHECK_EN
      state_q     <= state_d;
      frame_err_q <= frame_err_d;
`endif
    end
  end

  assign m_valid   = m_valid_q;
  assign m_feat    = m_feat_q;
  assign frame_cnt = frame_cnt_q;
`ifdef LAYER0_PACKER_FRAME_CHECK_EN
  assign frame_err = frame_err_q;
`else
  assign frame_err = 1'b0;
`endif

endmodule
